// File: rtl/ball_pkg.sv
// ball_pkg: shared types and constants for the ball motion engine.
//   ball_state_t : FSM state encoding (IDLE, MOVE, LOST)
//   DIR_INC      : direction flag value for an increasing coordinate
//   DIR_DEC      : direction flag value for a decreasing coordinate
package ball_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MOVE = 2'd1,
        LOST = 2'd2
    } ball_state_t;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

endpackage

// File: rtl/ball_mover_axis_stepper.sv
// axis_stepper: combinational next-position / next-direction logic for one
// axis of the ball. Holds no state; the registers live in ball_mover.
//
// Parameters: W (coordinate width), MAX (largest legal coordinate, inclusive),
//             STEP (pixels moved per step).
// Ports:
//   pos      in  W   current coordinate
//   dir      in  1   current direction (DIR_INC / DIR_DEC)
//   flip     in  1   reverse the direction before stepping
//   step_en  in  1   advance the coordinate this cycle
//   next_pos out W   coordinate after this cycle
//   next_dir out 1   direction after this cycle
//   hit_lo   out 1   step clamped at 0 (low wall reflection)
//   hit_hi   out 1   step clamped at MAX (high wall reflection)
module axis_stepper
    import ball_pkg::*;
#(
    parameter int W    = 8,
    parameter int MAX  = 159,
    parameter int STEP = 1
) (
    input  logic [W-1:0] pos,
    input  logic         dir,
    input  logic         flip,
    input  logic         step_en,
    output logic [W-1:0] next_pos,
    output logic         next_dir,
    output logic         hit_lo,
    output logic         hit_hi
);

    // One extra bit so pos+STEP can exceed MAX without wrapping.
    localparam logic [W:0] STEP_EXT = (W+1)'(STEP);
    localparam logic [W:0] MAX_EXT  = (W+1)'(MAX);

    logic         eff_dir;
    logic [W:0]   sum;

    assign eff_dir = dir ^ flip;
    assign sum     = {1'b0, pos} + STEP_EXT;

    always_comb begin
        next_pos = pos;
        next_dir = eff_dir;
        hit_lo   = 1'b0;
        hit_hi   = 1'b0;
        if (step_en) begin
            if (eff_dir == DIR_INC) begin
                if (sum > MAX_EXT) begin
                    next_pos = W'(MAX);
                    next_dir = DIR_DEC;
                    hit_hi   = 1'b1;
                end else begin
                    next_pos = sum[W-1:0];
                end
            end else begin
                if ({1'b0, pos} < STEP_EXT) begin
                    next_pos = '0;
                    next_dir = DIR_INC;
                    hit_lo   = 1'b1;
                end else begin
                    next_pos = pos - W'(STEP);
                end
            end
        end
    end

endmodule

// File: rtl/ball_mover.sv
// ball_mover: ball motion engine. Holds the ball at the serve position until
// launched, then steps X and Y on each enable tick, reflecting off the left,
// right and top walls and applying flip requests from the collision logic.
// A bottom-edge hit produces a one-cycle lost pulse and a return to serve.
//
// Compile option: define BALL_BOTTOM_WALL_EN to make the bottom edge reflect
// like the other walls (lost is then never asserted).
//
// Ports:
//   clk     in  1    system clock
//   resetn  in  1    asynchronous active-low reset
//   enable  in  1    movement tick (one step per pulse)
//   launch  in  1    serve request, honoured in IDLE
//   flip_x  in  1    reverse X direction
//   flip_y  in  1    reverse Y direction
//   x       out X_W  ball X
//   y       out Y_W  ball Y
//   x_du    out 1    X direction, 1 = right
//   y_du    out 1    Y direction, 1 = down
//   moving  out 1    high in MOVE
//   lost    out 1    one-cycle pulse after a bottom-edge hit
module ball_mover
    import ball_pkg::*;
#(
    parameter int X_W    = 8,
    parameter int Y_W    = 7,
    parameter int X_MAX  = 159,
    parameter int Y_MAX  = 119,
    parameter int X_INIT = 80,
    parameter int Y_INIT = 100,
    parameter int STEP   = 1
) (
    input  logic           clk,
    input  logic           resetn,
    input  logic           enable,
    input  logic           launch,
    input  logic           flip_x,
    input  logic           flip_y,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           x_du,
    output logic           y_du,
    output logic           moving,
    output logic           lost
);

    ball_state_t    state;

    logic [X_W-1:0] x_next;
    logic [Y_W-1:0] y_next;
    logic           x_du_next;
    logic           y_du_next;
    logic           x_hit_lo, x_hit_hi;
    logic           y_hit_lo, y_hit_hi;

    axis_stepper #(.W(X_W), .MAX(X_MAX), .STEP(STEP)) u_axis_x (
        .pos      (x),
        .dir      (x_du),
        .flip     (flip_x),
        .step_en  (enable),
        .next_pos (x_next),
        .next_dir (x_du_next),
        .hit_lo   (x_hit_lo),
        .hit_hi   (x_hit_hi)
    );

    axis_stepper #(.W(Y_W), .MAX(Y_MAX), .STEP(STEP)) u_axis_y (
        .pos      (y),
        .dir      (y_du),
        .flip     (flip_y),
        .step_en  (enable),
        .next_pos (y_next),
        .next_dir (y_du_next),
        .hit_lo   (y_hit_lo),
        .hit_hi   (y_hit_hi)
    );

    // Wall hits other than the bottom one are fully handled inside the steppers.
`ifdef BALL_BOTTOM_WALL_EN
    logic unused_hits;
    assign unused_hits = x_hit_lo ^ x_hit_hi ^ y_hit_lo ^ y_hit_hi;
`else
    logic unused_hits;
    assign unused_hits = x_hit_lo ^ x_hit_hi ^ y_hit_lo;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state  <= IDLE;
            x      <= X_W'(X_INIT);
            y      <= Y_W'(Y_INIT);
            x_du   <= DIR_INC;
            y_du   <= DIR_DEC;
            moving <= 1'b0;
            lost   <= 1'b0;
        end else begin
            lost <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        state  <= MOVE;
                        moving <= 1'b1;
                    end
                end
                MOVE: begin
                    // X always takes the stepper result, even on a bottom-corner loss.
                    x    <= x_next;
                    x_du <= x_du_next;
`ifdef BALL_BOTTOM_WALL_EN
                    y    <= y_next;
                    y_du <= y_du_next;
`else
                    if (y_hit_hi) begin
                        y      <= Y_W'(Y_MAX);
                        state  <= LOST;
                        moving <= 1'b0;
                        lost   <= 1'b1;
                    end else begin
                        y    <= y_next;
                        y_du <= y_du_next;
                    end
`endif
                end
                LOST: begin
                    state <= IDLE;
                    x     <= X_W'(X_INIT);
                    y     <= Y_W'(Y_INIT);
                    x_du  <= DIR_INC;
                    y_du  <= DIR_DEC;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ball_mover.sv
// tb_ball_mover: directed bench for ball_mover. A default-parameter instance
// covers serve, stepping, wall reflections, flips, the bottom edge and reset;
// a STEP=3 instance served near the right wall covers the clamped reflection.
// Works with or without BALL_BOTTOM_WALL_EN defined.
module tb_ball_mover;

    logic       clk;
    logic       resetn;
    logic       enable, launch, flip_x, flip_y;
    logic [7:0] x;
    logic [6:0] y;
    logic       x_du, y_du, moving, lost;

    logic       enable3, launch3;
    logic [7:0] x3;
    logic [6:0] y3;
    logic       x_du3, y_du3, moving3, lost3;

    int checks = 0;
    int errors = 0;
    int lost_seen = 0;

    ball_mover u_dut (
        .clk    (clk),
        .resetn (resetn),
        .enable (enable),
        .launch (launch),
        .flip_x (flip_x),
        .flip_y (flip_y),
        .x      (x),
        .y      (y),
        .x_du   (x_du),
        .y_du   (y_du),
        .moving (moving),
        .lost   (lost)
    );

    ball_mover #(.STEP(3), .X_INIT(157), .Y_INIT(60)) u_dut3 (
        .clk    (clk),
        .resetn (resetn),
        .enable (enable3),
        .launch (launch3),
        .flip_x (1'b0),
        .flip_y (1'b0),
        .x      (x3),
        .y      (y3),
        .x_du   (x_du3),
        .y_du   (y_du3),
        .moving (moving3),
        .lost   (lost3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (lost === 1'b1) lost_seen++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Apply the given inputs for n cycles; returns 1 time unit after the last edge.
    task automatic tick(input logic en, input logic la, input logic fx, input logic fy, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            enable = en;
            launch = la;
            flip_x = fx;
            flip_y = fy;
            @(posedge clk);
            #1;
        end
        enable = 1'b0;
        launch = 1'b0;
        flip_x = 1'b0;
        flip_y = 1'b0;
    endtask

    initial begin
        resetn  = 1'b0;
        enable  = 1'b0;
        launch  = 1'b0;
        flip_x  = 1'b0;
        flip_y  = 1'b0;
        enable3 = 1'b0;
        launch3 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;

        check("reset_x", x, 80);
        check("reset_y", y, 100);
        check("reset_x_du", x_du, 1);
        check("reset_y_du", y_du, 0);
        check("reset_moving", moving, 0);
        check("reset_lost", lost, 0);

        // Enables before launch are ignored.
        tick(1, 0, 0, 0, 10);
        check("idle_x", x, 80);
        check("idle_y", y, 100);
        check("idle_moving", moving, 0);

        // Enable on the launch edge is not applied.
        tick(1, 1, 0, 0, 1);
        check("launch_moving", moving, 1);
        check("launch_x", x, 80);
        check("launch_y", y, 100);

        tick(1, 0, 0, 0, 3);
        check("step3_x", x, 83);
        check("step3_y", y, 97);
        check("step3_x_du", x_du, 1);
        check("step3_y_du", y_du, 0);

        // 76 steps to x=159, one clamped reflection, 19 more down.
        tick(1, 0, 0, 0, 96);
        check("right_wall_x", x, 140);
        check("right_wall_x_du", x_du, 0);
        check("near_top_y", y, 1);
        check("near_top_y_du", y_du, 0);

        tick(1, 0, 0, 0, 1);
        check("top_y0", y, 0);
        check("top_y0_du", y_du, 0);
        tick(1, 0, 0, 0, 1);
        check("top_hit_y", y, 0);
        check("top_hit_y_du", y_du, 1);
        tick(1, 0, 0, 0, 1);
        check("top_leave_y", y, 1);
        check("top_leave_x", x, 137);

        tick(1, 0, 0, 0, 49);
        check("mid_y", y, 50);
        check("mid_x", x, 88);

        tick(1, 0, 0, 1, 1);
        check("flipy_en_y", y, 49);
        check("flipy_en_y_du", y_du, 0);
        tick(1, 0, 0, 1, 1);
        check("flipy_en2_y", y, 50);
        check("flipy_en2_y_du", y_du, 1);
        check("flipy_en2_x", x, 86);

        // Flips without enable change direction only.
        tick(0, 0, 1, 0, 1);
        check("flipx_x", x, 86);
        check("flipx_x_du", x_du, 1);
        check("flipx_y", y, 50);
        tick(0, 0, 0, 1, 1);
        check("flipy_y_du", y_du, 0);
        tick(0, 0, 0, 1, 1);
        check("flipy_back_y_du", y_du, 1);
        check("flipy_back_y", y, 50);

        tick(1, 0, 0, 0, 69);
        check("pre_bottom_y", y, 119);
        check("pre_bottom_x", x, 155);
        check("pre_bottom_lost", lost, 0);

        tick(1, 0, 0, 0, 1);
        check("bottom_x", x, 156);
        check("bottom_y", y, 119);
`ifdef BALL_BOTTOM_WALL_EN
        check("bottom_y_du", y_du, 0);
        check("bottom_moving", moving, 1);
        check("bottom_lost", lost, 0);
        tick(1, 0, 0, 0, 1);
        check("bottom_after_y", y, 118);
        check("bottom_after_x", x, 157);
        check("bottom_after_lost", lost, 0);
        check("lost_pulses", lost_seen, 0);
`else
        check("bottom_lost", lost, 1);
        check("bottom_moving", moving, 0);
        tick(0, 0, 0, 0, 1);
        check("serve_lost", lost, 0);
        check("serve_x", x, 80);
        check("serve_y", y, 100);
        check("serve_x_du", x_du, 1);
        check("serve_y_du", y_du, 0);
        check("serve_moving", moving, 0);
        check("lost_pulses", lost_seen, 1);
        // IDLE ignores enable and flips.
        tick(1, 0, 1, 1, 1);
        check("idle2_x", x, 80);
        check("idle2_y", y, 100);
        check("idle2_x_du", x_du, 1);
        check("idle2_y_du", y_du, 0);
`endif

        @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("rst2_moving", moving, 0);

        tick(0, 1, 0, 0, 1);
        check("relaunch_moving", moving, 1);
        tick(1, 0, 0, 0, 40);
        check("run_x", x, 120);
        check("run_y", y, 60);

        // Asynchronous reset: checked before any further clock edge.
        @(posedge clk);
        #3;
        resetn = 1'b0;
        #1;
        check("async_x", x, 80);
        check("async_y", y, 100);
        check("async_x_du", x_du, 1);
        check("async_y_du", y_du, 0);
        check("async_moving", moving, 0);
        @(negedge clk);
        resetn = 1'b1;

        // STEP=3 instance served at x=157, y=60.
        @(negedge clk);
        launch3 = 1'b1;
        @(posedge clk);
        #1;
        launch3 = 1'b0;
        check("s3_moving", moving3, 1);
        @(negedge clk);
        enable3 = 1'b1;
        @(posedge clk);
        #1;
        enable3 = 1'b0;
        check("s3_wall_x", x3, 159);
        check("s3_wall_x_du", x_du3, 0);
        check("s3_wall_y", y3, 57);
        @(negedge clk);
        enable3 = 1'b1;
        @(posedge clk);
        #1;
        enable3 = 1'b0;
        check("s3_back_x", x3, 156);
        check("s3_back_y", y3, 54);
        check("s3_lost", lost3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
